// File: rtl/run_detector.sv
// Consecutive-ones run detector with run-time overlap mode and a saturating hit counter.
// Every output is a flop, so nothing combinational reaches the status/interrupt logic.
module run_detector #(
  parameter int RUN_LEN = 3,
  parameter int CNT_W   = 8,
  parameter int RW      = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in,
  input  logic             mode,
  input  logic             clear,
  output logic [RW-1:0]    run_count,
  output logic [1:0]       state,
  output logic             detect,
  output logic [CNT_W-1:0] hit_count,
  output logic             hit_sat
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HIT  = 2'b10
  } state_t;

  localparam logic [RW-1:0] LEN    = RW'(RUN_LEN);
  localparam logic [RW-1:0] LEN_M1 = RW'(RUN_LEN - 1);

  logic [RW-1:0]    r_run_count;
  logic             r_detect;
  logic [CNT_W-1:0] r_hit_count;
  logic             r_hit_sat;
  state_t           r_state;

  logic             w_event;
  logic [RW-1:0]    w_run_next;
  logic [CNT_W-1:0] w_hit_next;
  state_t           w_state_next;

  always_comb begin
    w_event    = in_valid & in & (r_run_count >= LEN_M1);
    w_run_next = r_run_count;
    if (in_valid) begin
      if (!in)
        w_run_next = '0;
      else if (w_event)
        w_run_next = mode ? LEN : '0;
      else
        w_run_next = r_run_count + 1'b1;
    end
  end

  // clear wins over a same-edge detection; the counter sticks at all ones
  always_comb begin
    w_hit_next = r_hit_count;
    if (clear)
      w_hit_next = '0;
    else if (w_event && (r_hit_count != '1))
      w_hit_next = r_hit_count + 1'b1;
  end

  always_comb begin
    if (w_run_next == '0)
      w_state_next = ST_IDLE;
    else if (w_run_next == LEN)
      w_state_next = ST_HIT;
    else
      w_state_next = ST_RUN;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run_count <= '0;
      r_state     <= ST_IDLE;
      r_detect    <= 1'b0;
      r_hit_count <= '0;
      r_hit_sat   <= 1'b0;
    end else begin
      r_run_count <= w_run_next;
      r_state     <= w_state_next;
      r_detect    <= w_event;
      r_hit_count <= w_hit_next;
      r_hit_sat   <= (w_hit_next == '1);
    end
  end

  assign run_count = r_run_count;
  assign state     = r_state;
  assign detect    = r_detect;
  assign hit_count = r_hit_count;
  assign hit_sat   = r_hit_sat;

endmodule
